// File: rtl/intr_ctl.sv
// Interrupt controller: NSRC synchronised sources, per-source level/edge mode,
// enables, fixed priority (0 highest), claim/complete with nesting, global enable.
module intr_ctl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDW         = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [3:0]      io_addr,
  input  logic            io_write,
  input  logic            io_read,
  input  logic [15:0]     io_wdata,
  output logic [15:0]     io_rdata,
  output logic            interrupt
);

  localparam logic [3:0] NSRC_ID = 4'(NSRC);

  logic [NSRC-1:0] s;
  logic [NSRC-1:0] prev_q, prev_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] insvc_q, insvc_d;
  logic            gie_q, gie_d;
  logic            irq_q, irq_d;

  logic [NSRC-1:0] rise, pending, eligible, claim_mask, cmpl_mask, clr;
  logic            valid, seen;
  logic [IDW-1:0]  claim_id;
  logic            wr_pend, wr_en, wr_mode, wr_ctrl, wr_cmpl, do_claim;
  logic            unused_wdata;

  assign unused_wdata = ^io_wdata;

  if (SYNC_STAGES == 0) begin : g_direct
    assign s = src;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;

    always_comb begin
      sync_d    = sync_q;
      sync_d[0] = src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    end

    always_ff @(posedge clk) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Level-mode bits follow the synchronised line; edge-mode bits come from the latch.
  always_comb begin
    rise    = s & ~prev_q;
    pending = (mode_q & pend_q) | (~mode_q & s);
  end

  // A source is eligible only if nothing at its own or higher priority is in service.
  always_comb begin
    eligible = '0;
    seen     = 1'b0;
    claim_id = '0;
    for (int i = 0; i < NSRC; i++) begin
      seen        = seen | insvc_q[i];
      eligible[i] = pending[i] & enable_q[i] & ~seen;
    end
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) claim_id = IDW'(i);
    end
    valid = |eligible;
  end

  always_comb begin
    wr_pend  = io_write & (io_addr == 4'd0);
    wr_en    = io_write & (io_addr == 4'd1);
    wr_mode  = io_write & (io_addr == 4'd2);
    wr_cmpl  = io_write & (io_addr == 4'd3) & (io_wdata[3:0] < NSRC_ID);
    wr_ctrl  = io_write & (io_addr == 4'd4);
    do_claim = io_read & ~io_write & (io_addr == 4'd3) & valid;

    claim_mask = do_claim ? (NSRC'(1) << claim_id) : '0;
    cmpl_mask  = wr_cmpl ? (NSRC'(1) << io_wdata[3:0]) : '0;

    mode_d   = wr_mode ? io_wdata[NSRC-1:0] : mode_q;
    enable_d = wr_en ? io_wdata[NSRC-1:0] : enable_q;
    gie_d    = wr_ctrl ? io_wdata[0] : gie_q;
    prev_d   = s;

    // Mode changes drop the old latch; a rise still sets under the new mode.
    clr    = (wr_pend ? io_wdata[NSRC-1:0] : '0) | (mode_d ^ mode_q) | claim_mask;
    pend_d = mode_d & (rise | (pend_q & ~clr));

    insvc_d = (insvc_q | claim_mask) & ~cmpl_mask;
    irq_d   = gie_q & valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q   <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      insvc_q  <= '0;
      gie_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      insvc_q  <= insvc_d;
      gie_q    <= gie_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    case (io_addr)
      4'd0:    io_rdata = 16'(pending);
      4'd1:    io_rdata = 16'(enable_q);
      4'd2:    io_rdata = 16'(mode_q);
      4'd3:    io_rdata = valid ? {1'b1, {(15-IDW){1'b0}}, claim_id} : 16'h0000;
      4'd4:    io_rdata = {15'b0, gie_q};
      4'd5:    io_rdata = 16'(insvc_q);
      default: io_rdata = 16'h0000;
    endcase
  end

  assign interrupt = irq_q;

endmodule

// File: tb/tb_intr_ctl.sv
// Bench for intr_ctl: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a behavioural model.
module tb_intr_ctl;
  localparam int N  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src;
  logic [3:0]    io_addr;
  logic          io_write, io_read;
  logic [15:0]   io_wdata;
  logic [15:0]   io_rdata;
  logic          interrupt;

  int n_vec  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  intr_ctl #(.NSRC(N), .SYNC_STAGES(SS), .IDW(4)) dut (
    .clk(clk), .reset(reset), .src(src), .io_addr(io_addr),
    .io_write(io_write), .io_read(io_read), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_s, m_prev, m_ep, m_en, m_mode, m_is;
  logic         m_gie, m_irq;

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_ep[i] : m_s[i];
    return p;
  endfunction

  function automatic int m_top();
    for (int i = 0; i < N; i++) if (m_is[i]) return i;
    return N;
  endfunction

  function automatic int m_claim_id();
    logic [N-1:0] p;
    int top;
    p   = m_pending();
    top = m_top();
    for (int i = 0; i < top; i++) if (p[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] m_rdata();
    int cid;
    case (io_addr)
      4'd0: return 16'(m_pending());
      4'd1: return 16'(m_en);
      4'd2: return 16'(m_mode);
      4'd3: begin
        cid = m_claim_id();
        return (cid >= 0) ? (16'h8000 | 16'(cid)) : 16'h0000;
      end
      4'd4: return {15'b0, m_gie};
      4'd5: return 16'(m_is);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model_upd
    int cid, cl;
    logic [N-1:0] rise, nmode, w1c;
    if (!reset) begin
      m_hist.delete();
      for (int k = 0; k < SS; k++) m_hist.push_back('0);
      m_s = '0; m_prev = '0; m_ep = '0; m_en = '0; m_mode = '0; m_is = '0;
      m_gie = 1'b0; m_irq = 1'b0;
    end else begin
      cid   = m_claim_id();
      m_irq = m_gie && (cid >= 0);
      rise  = m_s & ~m_prev;
      nmode = (io_write && io_addr == 4'd2) ? io_wdata[N-1:0] : m_mode;
      w1c   = (io_write && io_addr == 4'd0) ? io_wdata[N-1:0] : '0;
      cl    = (io_read && !io_write && io_addr == 4'd3) ? cid : -1;
      for (int i = 0; i < N; i++) begin
        if (!nmode[i])                                        m_ep[i] = 1'b0;
        else if (rise[i])                                     m_ep[i] = 1'b1;
        else if (w1c[i] || cl == i || nmode[i] != m_mode[i])  m_ep[i] = 1'b0;
      end
      if (cl >= 0) m_is[cl] = 1'b1;
      if (io_write && io_addr == 4'd3 && io_wdata[3:0] < N) m_is[io_wdata[3:0]] = 1'b0;
      if (io_write && io_addr == 4'd1) m_en = io_wdata[N-1:0];
      if (io_write && io_addr == 4'd4) m_gie = io_wdata[0];
      m_mode = nmode;
      m_prev = m_s;
      m_hist.push_back(src);
      void'(m_hist.pop_front());
      m_s = m_hist[0];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_irq", {15'b0, interrupt}, {15'b0, m_irq});
      check("model_rdata", io_rdata, m_rdata());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_addr = a; io_wdata = d; io_write = 1'b1;
    cyc();
    io_write = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [15:0] exp, input string name);
    io_addr = a;
    #1;
    check(name, io_rdata, exp);
  endtask

  task automatic claim_chk(input logic [15:0] exp, input string name);
    io_addr = 4'd3; io_read = 1'b1;
    #1;
    check(name, io_rdata, exp);
    cyc();
    io_read = 1'b0;
  endtask

  task automatic irq_chk(input logic exp, input string name);
    check(name, {15'b0, interrupt}, {15'b0, exp});
  endtask

  task automatic pulse(input int b);
    src = N'(1) << b;
    cyc();
    src = '0;
    repeat (3) cyc();
  endtask

  initial begin
    int op;
    reset = 1'b0; src = '0; io_addr = '0; io_write = 1'b0; io_read = 1'b0; io_wdata = '0;
    repeat (3) cyc();
    chk_en = 1'b1;
    reset  = 1'b1;

    // Reset state
    for (int a = 0; a < 8; a++) rd_chk(4'(a), 16'h0000, "reset_reg");
    irq_chk(1'b0, "reset_irq");

    // Edge-mode single pulse
    wr(4'd2, 16'h0004); wr(4'd1, 16'h0004); wr(4'd4, 16'h0001);
    src = 8'h04; cyc(); src = '0;
    cyc(); cyc();
    rd_chk(4'd0, 16'h0004, "edge_pending");
    irq_chk(1'b0, "edge_irq_pre");
    cyc();
    irq_chk(1'b1, "edge_irq");
    claim_chk(16'h8002, "edge_claim");
    rd_chk(4'd0, 16'h0000, "edge_pend_clr");
    rd_chk(4'd5, 16'h0004, "edge_insvc");
    cyc();
    irq_chk(1'b0, "edge_irq_drop");
    wr(4'd3, 16'h0002);

    // Level mode
    wr(4'd2, 16'h0000); wr(4'd1, 16'h00FF);
    src = 8'h20;
    repeat (3) cyc();
    irq_chk(1'b1, "lvl_irq");
    claim_chk(16'h8005, "lvl_claim");
    cyc();
    irq_chk(1'b0, "lvl_irq_insvc");
    rd_chk(4'd0, 16'h0020, "lvl_pending");
    wr(4'd3, 16'h0005);
    irq_chk(1'b0, "lvl_irq_cmpl_edge");
    cyc();
    irq_chk(1'b1, "lvl_irq_reassert");
    src = '0;
    repeat (3) cyc();

    // Nesting
    wr(4'd2, 16'h00FF);
    pulse(3);
    claim_chk(16'h8003, "nest_claim3");
    pulse(1);
    irq_chk(1'b1, "nest_irq1");
    claim_chk(16'h8001, "nest_claim1");
    rd_chk(4'd5, 16'h000A, "nest_insvc");
    pulse(4);
    irq_chk(1'b0, "nest_irq4_blocked");
    rd_chk(4'd0, 16'h0010, "nest_pend4");
    wr(4'd3, 16'h0001); cyc();
    irq_chk(1'b0, "nest_after_c1");
    wr(4'd3, 16'h0003); cyc();
    irq_chk(1'b1, "nest_after_c3");
    claim_chk(16'h8004, "nest_claim4");
    wr(4'd3, 16'h0004);

    // Rise and W1C in the same cycle; claim with nothing eligible
    src = 8'h01; cyc(); cyc();
    wr(4'd0, 16'h0001);
    rd_chk(4'd0, 16'h0001, "simul_pend");
    claim_chk(16'h8000, "simul_claim0");
    claim_chk(16'h0000, "claim_none");
    rd_chk(4'd5, 16'h0001, "claim_none_insvc");
    wr(4'd3, 16'h0000);
    src = '0; cyc();

    // GIE=0 masks output only; bad complete id ignored
    wr(4'd4, 16'h0000);
    pulse(6);
    irq_chk(1'b0, "gie_off_irq");
    claim_chk(16'h8006, "gie_off_claim");
    wr(4'd3, 16'h0006);
    pulse(7);
    claim_chk(16'h8007, "claim7");
    wr(4'd3, 16'h000F);
    rd_chk(4'd5, 16'h0080, "cmpl_bad_id");
    wr(4'd3, 16'h0007);
    rd_chk(4'd5, 16'h0000, "cmpl7");

    // Reset during a claim
    wr(4'd4, 16'h0001);
    pulse(2);
    io_addr = 4'd3; io_read = 1'b1; reset = 1'b0;
    cyc();
    reset = 1'b1; io_read = 1'b0;
    rd_chk(4'd5, 16'h0000, "rst_claim_insvc");
    irq_chk(1'b0, "rst_claim_irq");

    // Randomized run
    wr(4'd1, 16'($urandom)); wr(4'd2, 16'($urandom)); wr(4'd4, 16'h0001);
    for (int c = 0; c < 4000; c++) begin
      src = src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      op  = $urandom_range(0, 19);
      if (op <= 2) begin
        io_addr  = 4'($urandom_range(0, 7));
        io_wdata = 16'($urandom);
        if (io_addr == 4'd4 && $urandom_range(0, 3) != 0) io_wdata[0] = 1'b1;
        io_write = 1'b1;
      end else if (op <= 7) begin
        io_addr = 4'd3; io_read = 1'b1;
      end else if (op <= 10) begin
        io_addr = 4'd3; io_wdata = 16'($urandom_range(0, 9)); io_write = 1'b1;
      end else if (op == 11) begin
        io_addr = 4'($urandom_range(0, 15)); io_wdata = 16'($urandom);
        io_read = 1'b1; io_write = 1'b1;
      end else begin
        io_addr = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      cyc();
      io_read = 1'b0; io_write = 1'b0; reset = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/intr_ctl.md
Name: intr_ctl

Overview:
- Parametrised successor to the fixed two-source interrupt block: NSRC sources, per-source level/edge mode, enables, fixed priority, claim/complete with nesting, global enable.
- Sits on the 16-bit I/O bus at an addr[7:5] slot.
- Drives the single `interrupt` line into execute.
- Sources arrive asynchronously (uart, sd, timers) and are synchronised internally.

Parameters:
- NSRC, 8, number of interrupt sources, 1..15; source 0 is highest priority.
- SYNC_STAGES, 2, synchroniser flops per source, 0..3; 0 means direct.
- IDW, 4, width of the claim ID field; fixed.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low; state clears on a clk edge while reset==0.
- src  input  NSRC  raw interrupt request lines.
- io_addr  input  4  register word index (addr[4:1]).
- io_write  input  1  one-cycle register write strobe.
- io_read  input  1  one-cycle register read strobe; needed for claim side effects.
- io_wdata  input  16  write data.
- io_rdata  output  16  read data, combinational from io_addr.
- interrupt  output  1  registered interrupt request to the core.

Behaviour:
- Reset (reset==0 at a clk edge) clears synchroniser chains, edge-detect prev regs, PENDING, ENABLE, MODE, INSERVICE, GIE and interrupt.
- After reset, a source held high in edge mode raises one edge, because prev resets to 0.
- Sync path: src[i] -> SYNC_STAGES flops -> s[i]. prev[i] <= s[i]. rise[i] = s[i] & ~prev[i].
- Register map (word index):
  - 0 PENDING, RW1C.
  - 1 ENABLE, RW.
  - 2 MODE, RW; 1=rising edge, 0=level.
  - 3 CLAIM/COMPLETE.
  - 4 CTRL, bit0=GIE.
  - 5 INSERVICE, RO.
  - Others read 0; writes to them are ignored.
  - Bits >= NSRC read 0 and ignore writes.
- Edge-mode pending[i]:
  - Set on rise[i].
  - Cleared by a PENDING write with bit i=1, or by a claim of i.
  - Set wins over clear in the same cycle.
- Level-mode pending[i]: pending[i] = s[i]; W1C and claim have no effect on it.
- MODE write: pending bits whose mode changes are cleared that cycle. A rise in the same cycle still sets under the new mode.
- Priority mask:
  - top_is = lowest index with INSERVICE set, or NSRC if none.
  - eligible[i] = pending[i] & enable[i] & (i < top_is).
- Output: interrupt <= GIE & |eligible, registered.
  - Latency is 1 clk from the pending/enable/GIE change to interrupt, and 1 clk from claim/complete to interrupt drop or rise.
- CLAIM read (io_read & io_addr==3):
  - io_rdata = {valid, 11'b0, id}, where id = lowest eligible index and valid = |eligible.
  - If none is eligible, io_rdata = 16'h0000 and there is no side effect.
  - If valid, at the clk edge: INSERVICE[id] <= 1, and edge pending[id] <= 0 unless rise[id] in the same cycle.
  - Side effect occurs once per cycle io_read is high.
- COMPLETE write (io_write & io_addr==3):
  - INSERVICE[io_wdata[3:0]] <= 0 if id < NSRC; otherwise ignored.
  - Completing a non-in-service id has no effect.
- Reads of addresses other than 3 have no side effects.
- io_read and io_write are never both high; if they are, the write takes effect and the read has no side effect.
- GIE=0 masks only the output. Pending still latches and claims still work.
- Nesting: a higher-priority source may interrupt while a lower one is in service. Equal or lower priority waits for COMPLETE.

Test Plan:
- Reset, then read all regs -> 0; interrupt=0. Hold reset=0 mid-claim -> INSERVICE=0 next edge.
- MODE=0x0004, ENABLE=0x0004, GIE=1, pulse src[2] one cycle -> PENDING=0x0004 after SYNC_STAGES+1 clks; interrupt high 1 clk later; CLAIM reads 0x8002; PENDING=0, INSERVICE=0x0004, interrupt low next clk.
- Level mode: ENABLE=0x00FF, src[5]=1 -> CLAIM reads 0x8005; src[5] still high; PENDING[5] stays 1; interrupt low while in service; COMPLETE 5 with src still high -> interrupt reasserts 1 clk later.
- Nesting: claim 3, then edge on src[1] -> CLAIM 0x8001, INSERVICE=0x000A. Edge on src[4] -> no interrupt until both completes. COMPLETE 1 then 3 -> interrupt rises, CLAIM 0x8004.
- Simultaneous: edge-mode src[0] rising in the same cycle as a W1C write to PENDING bit0 -> PENDING[0]=1. CLAIM with nothing eligible -> 0x0000, INSERVICE unchanged.
- GIE=0 with pending enabled -> interrupt stays 0, CLAIM still returns valid. COMPLETE with id 0xF -> ignored.
